aer_event_receiver: RTL
=======================

Name: aer_event_receiver

Overview:
Clocked sink that sits directly downstream of the AER channel. It consumes the four channel output lines (Ch1Up_Out, Ch1Down_Out, Ch2Up_Out, Ch2Down_Out), which are asynchronous to the system clock. It synchronises them, detects events (rising edges) and keeps a signed net position count per channel. It also queues event codes, in arrival order, into a FIFO read through a valid/ready port.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops per input line (minimum 2)
FIFO_DEPTH, 8, event FIFO entries (power of 2, minimum 2)
CNT_W, 16, width of signed position counters

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
Ch1Up  input  1  async event line, channel 1 up
Ch1Down  input  1  async event line, channel 1 down
Ch2Up  input  1  async event line, channel 2 up
Ch2Down  input  1  async event line, channel 2 down
clear  input  1  sync clear of counters and overflow flag
ev_code  output  2  head-of-FIFO event code
ev_valid  output  1  FIFO non-empty
ev_ready  input  1  consumer accepts head when ev_valid
pos_ch1  output  CNT_W  signed net count, channel 1
pos_ch2  output  CNT_W  signed net count, channel 2
overflow  output  1  sticky: event lost

Behaviour:
- Reset (reset=0, asynchronous) clears the following; release is synchronous to clk:
  - synchronisers, edge registers, pending flags, FIFO pointers;
  - pos_ch1=0, pos_ch2=0, overflow=0, ev_valid=0, ev_code=0.
- Event codes:
  - 2'b00 Ch1Up, 2'b01 Ch1Down, 2'b10 Ch2Up, 2'b11 Ch2Down.
- Synchroniser and edge detection:
  - Each line passes through SYNC_STAGES flops, then one edge register.
  - An event is detected when sync output is 1 and the edge register is 0.
  - Edge detection is masked for the first SYNC_STAGES+1 cycles after reset release, so a line already high at release produces no event.
- Counters:
  - Updated in the cycle after detection, independent of FIFO state.
  - Up adds +1 and Down adds -1.
  - Up and Down on the same channel in the same cycle give a net 0.
  - Counters saturate at +2^(CNT_W-1)-1 and -2^(CNT_W-1); they never wrap.
- Pending flags:
  - A detected event sets a per-line pending flag.
- Arbitration:
  - Fixed priority Ch1Up > Ch1Down > Ch2Up > Ch2Down.
  - At most one push per cycle, taken from the highest-priority pending flag when the FIFO is not full or is popping in that cycle.
  - The pushed line's pending flag clears.
- Overflow:
  - A new event on a line whose pending flag is still set is dropped from the FIFO (the counter still counts) and sets overflow.
  - overflow stays 1 until clear or reset.
- FIFO:
  - Show-ahead: ev_code and ev_valid come straight from the head.
  - Pop occurs when ev_valid and ev_ready are both 1.
  - Simultaneous push and pop is legal when full or when empty; when empty, the pushed entry appears next cycle.
  - ev_ready with ev_valid=0 is ignored.
- Latency: with the FIFO empty and no contention, ev_valid rises SYNC_STAGES+2 clocks after the first clk edge that samples the line high (4 at defaults).
- clear:
  - Synchronous; zeroes pos_ch1, pos_ch2 and overflow.
  - FIFO and pending flags are unaffected.
  - If clear coincides with a counter update, the counter becomes the update alone (0+1 or 0-1).
- Line held high: produces exactly one event; it must go low (seen by the synchroniser) before the next.
- Reset asserted mid-operation: queued and pending events are discarded immediately.

Decomposition:
- Shared include aer_defs.vh holds the four event-code constants, shared with any AER transmitter.
- One natural sub-module, aer_sync_edge:
  - parameter SYNC_STAGES;
  - ports clk, reset, async_in, arm, edge_out;
  - instantiated four times.
- The FIFO and arbiter stay inline.

Test Plan:
1. Reset, then a single Ch1Up pulse of 3 cycles -> ev_valid high on cycle 4 with ev_code=00; pos_ch1=+1; pop clears ev_valid; overflow=0.
2. Ch2Up and Ch2Down rise in the same cycle, ev_ready=1 -> codes 10 then 11 on consecutive cycles; pos_ch2 unchanged at 0.
3. All four lines rise together -> FIFO order 00, 01, 10, 11; pos_ch1=0, pos_ch2=0.
4. ev_ready=0, then 9 Ch1Up events (rise, fall, rise, ...) -> FIFO holds 8 and the 9th is pending. A 10th event sets overflow=1 with pos_ch1=+10. Then ev_ready=1 -> 9 codes of 00 drain.
5. With CNT_W=4, 9 Ch1Up events -> pos_ch1 saturates at +7. Then clear -> pos_ch1=0 and overflow=0 while the FIFO still holds its entries.
6. Ch1Down held high through reset release -> no event and pos_ch1=0. Reset asserted with 3 events queued -> ev_valid=0 immediately, and it stays 0 after release.

Source files
------------

// File: rtl/aer_event_receiver_pkg.sv
// Shared definitions for the AER event receiver: line count, event-code
// encoding and the fixed-priority pick used by the FIFO arbiter.
package aer_event_receiver_pkg;

    localparam int unsigned NUM_LINES = 4;
    localparam int unsigned CODE_W    = 2;

    // Event codes double as line indices into the {Ch2Down, Ch2Up, Ch1Down, Ch1Up} vector.
    typedef enum logic [CODE_W-1:0] {
        EV_CH1_UP   = 2'b00,
        EV_CH1_DOWN = 2'b01,
        EV_CH2_UP   = 2'b10,
        EV_CH2_DOWN = 2'b11
    } ev_code_e;

    // Lowest set index wins: Ch1Up > Ch1Down > Ch2Up > Ch2Down.
    function automatic logic [CODE_W-1:0] prio_pick(input logic [NUM_LINES-1:0] req);
        logic [CODE_W-1:0] sel;
        sel = '0;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (req[i]) sel = CODE_W'(i);
        end
        return sel;
    endfunction

endpackage

// File: rtl/aer_event_receiver_if.sv
// Show-ahead event stream from the receiver FIFO to its consumer.
//   ev_code  : head-of-FIFO event code (source -> sink)
//   ev_valid : FIFO non-empty            (source -> sink)
//   ev_ready : consumer takes the head   (sink -> source)
interface aer_event_receiver_if;
    import aer_event_receiver_pkg::*;

    logic [CODE_W-1:0] ev_code;
    logic              ev_valid;
    logic              ev_ready;

    modport master (output ev_code, output ev_valid, input ev_ready);
    modport slave  (input ev_code, input ev_valid, output ev_ready);
endinterface

// File: rtl/aer_sync_edge.sv
// Synchroniser plus rising-edge detector for one asynchronous AER line.
//   clk, reset : system clock, async active-low reset
//   async_in   : raw line, asynchronous to clk
//   arm        : enables detection (low during the post-reset settle window)
//   edge_out   : one-cycle pulse when the synchronised line rises
module aer_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    input  logic arm,
    output logic edge_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;

    // Synchroniser chain followed by the previous-value register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_out = arm & sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/aer_event_receiver.sv
// AER event receiver: synchronises the four channel lines, counts net
// position per channel with saturation, and queues event codes in
// arrival order into a show-ahead FIFO.
//   clk, reset          : system clock, async active-low reset
//   Ch1Up..Ch2Down      : asynchronous event lines
//   clear               : sync clear of position counters and overflow
//   ev                  : event stream (code/valid/ready)
//   pos_ch1, pos_ch2    : signed saturating net counts
//   overflow            : sticky, an event was lost from the FIFO path
module aer_event_receiver
    import aer_event_receiver_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    Ch1Up,
    input  logic                    Ch1Down,
    input  logic                    Ch2Up,
    input  logic                    Ch2Down,
    input  logic                    clear,
    aer_event_receiver_if.master    ev,
    output logic signed [CNT_W-1:0] pos_ch1,
    output logic signed [CNT_W-1:0] pos_ch2,
    output logic                    overflow
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned ARM_N = SYNC_STAGES + 1;
    localparam int unsigned ARM_W = $clog2(SYNC_STAGES + 2);

    logic [ARM_W-1:0]     arm_cnt;
    logic                 arm;
    logic [NUM_LINES-1:0] lines;
    logic [NUM_LINES-1:0] det;
    logic [NUM_LINES-1:0] pend;
    logic [NUM_LINES-1:0] pend_nx;
    logic [NUM_LINES-1:0] push_oh;
    logic [NUM_LINES-1:0] drop;
    logic [CODE_W-1:0]    mem [FIFO_DEPTH];
    logic [PTR_W:0]       wr_ptr;
    logic [PTR_W:0]       rd_ptr;
    logic                 empty;
    logic                 full;
    logic                 pop;
    logic                 push;
    logic [CODE_W-1:0]    push_code;

    // Saturating counter step; clear discards the old value but keeps this cycle's update.
    function automatic logic signed [CNT_W-1:0] next_pos(
        input logic signed [CNT_W-1:0] cur,
        input logic                    up,
        input logic                    dn,
        input logic                    clr
    );
        logic signed [CNT_W:0] sum;
        sum = clr ? '0 : {cur[CNT_W-1], cur};
        if (up && !dn)      sum = sum + (CNT_W+1)'(1);
        else if (dn && !up) sum = sum - (CNT_W+1)'(1);
        if (sum[CNT_W] != sum[CNT_W-1])
            return sum[CNT_W] ? {1'b1, {(CNT_W-1){1'b0}}} : {1'b0, {(CNT_W-1){1'b1}}};
        return sum[CNT_W-1:0];
    endfunction

    assign lines = {Ch2Down, Ch2Up, Ch1Down, Ch1Up};

    // Hold off detection until the synchronisers hold post-reset samples,
    // so a line already high at reset release is not taken as an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)   arm_cnt <= '0;
        else if (!arm) arm_cnt <= arm_cnt + ARM_W'(1);
    end
    assign arm = (arm_cnt == ARM_W'(ARM_N));

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
        aer_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
            .clk      (clk),
            .reset    (reset),
            .async_in (lines[g]),
            .arm      (arm),
            .edge_out (det[g])
        );
    end

    // FIFO status, arbitration and pending-flag update.
    always_comb begin
        empty     = (wr_ptr == rd_ptr);
        full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
        pop       = !empty && ev.ev_ready;
        push      = (|pend) && (!full || pop);
        push_code = prio_pick(pend);
        push_oh   = push ? (NUM_LINES'(1) << push_code) : '0;
        // An event is lost only if its line is still pending after this cycle's push.
        drop      = det & pend & ~push_oh;
        pend_nx   = (pend & ~push_oh) | det;
    end

    assign ev.ev_valid = !empty;
    assign ev.ev_code  = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= push_code;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            pend   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            pend <= pend_nx;
        end
    end

    // Counters track every detected edge, independent of FIFO state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos_ch1  <= '0;
            pos_ch2  <= '0;
            overflow <= 1'b0;
        end else begin
            pos_ch1  <= next_pos(pos_ch1, det[EV_CH1_UP], det[EV_CH1_DOWN], clear);
            pos_ch2  <= next_pos(pos_ch2, det[EV_CH2_UP], det[EV_CH2_DOWN], clear);
            overflow <= (overflow & ~clear) | (|drop);
        end
    end

endmodule
